seven_segment_mux: RTL

//  Multiplexed N-digit seven-segment display driver; successor to the single-digit decoder.
//  - Scans NUM_DIGITS digits: one digit lit per time slot, with a blanking gap between slots.
//  - Optional hex glyphs, runtime leading-zero suppression and per-digit decimal points.
//  - Loads new values without tearing, synchronised to the frame boundary.
//  - Sits between the measurement/status logic and the board's common-anode display pins.

---
 rtl/seven_segment_mux_if.sv | 25 ++
 rtl/seven_segment_mux.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seven_segment_mux_if.sv
// Display-driver bus: value/control from the host logic, scan outputs to the pins.
// master = host side (drives value, dp_in, update, enable, lz_en); slave = driver.
interface seven_segment_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    update;
    logic                    enable;
    logic                    lz_en;
    logic [6:0]              seven_segment;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic                    frame_done;

    modport master (
        output value, dp_in, update, enable, lz_en,
        input  seven_segment, dp_n, anode_n, frame_done
    );

    modport slave (
        input  value, dp_in, update, enable, lz_en,
        output seven_segment, dp_n, anode_n, frame_done
    );
endinterface

// File: rtl/seven_segment_mux.sv
// Multiplexed N-digit common-anode seven-segment driver with blanking gap,
// hex glyphs, leading-zero suppression, decimal points and frame-synced loads.
// Ports: clk, rst_n (async, active low), bus (seven_segment_mux_if.slave):
//   in  value/dp_in/update/enable/lz_en, out seven_segment/dp_n/anode_n/frame_done.
module seven_segment_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int HEX_EN       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    seven_segment_mux_if.slave bus
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [DW-1:0] BLANK    = DW'(BLANK_CYCLES);

    logic [DW-1:0]         div_cnt_q, div_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [VW-1:0]         disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] anode_n_q, anode_n_d;
    logic                  frame_done_q, frame_done_d;

    logic                  boundary;
    logic                  frame_end;
    logic                  lit;
    logic [3:0]            nib;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] g;
        case (c)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        if (HEX_EN == 0 && c > 4'h9) begin
            g = 7'h7F;
        end
        return g;
    endfunction

    // Digit i is a leading zero when it and every higher nibble are zero.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (disp_val_q[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    always_comb begin
        div_cnt_d    = div_cnt_q;
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pending_d    = pending_q;

        boundary  = bus.enable && (idx_q == '0) && (div_cnt_q == '0);
        frame_end = bus.enable && (idx_q == IDX_LAST)
                    && (div_cnt_q == DIV_LAST);

        if (!bus.enable) begin
            div_cnt_d = '0;
            idx_d     = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        if (boundary && pending_q) begin
            disp_val_d = shadow_val_q;
            disp_dp_d  = shadow_dp_q;
            pending_d  = 1'b0;
        end

        // A strobe on the boundary itself lands after the transfer above,
        // so it stays pending for the following frame.
        if (bus.update) begin
            shadow_val_d = bus.value;
            shadow_dp_d  = bus.dp_in;
            pending_d    = 1'b1;
        end
    end

    always_comb begin
        nib          = disp_val_q[{idx_q, 2'b00} +: 4];
        lit          = bus.enable && (div_cnt_q >= BLANK);
        seg_d        = 7'h7F;
        dp_n_d       = 1'b1;
        anode_n_d    = '1;
        frame_done_d = frame_end;
        if (lit) begin
            anode_n_d[idx_q] = 1'b0;
            seg_d  = (bus.lz_en && lz_mask[idx_q]) ? 7'h7F : glyph(nib);
            dp_n_d = ~disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            seg_q        <= 7'h7F;
            dp_n_q       <= 1'b1;
            anode_n_q    <= '1;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            anode_n_q    <= anode_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seven_segment = seg_q;
    assign bus.dp_n          = dp_n_q;
    assign bus.anode_n       = anode_n_q;
    assign bus.frame_done    = frame_done_q;
endmodule
